// File: rtl/rcc_mux_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
// No logic; state encoding and default sizing only.
// Backpressure: n/a.
package rcc_mux_pkg;

    localparam int N_DEFAULT = 9;
    localparam int M_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mux_n_to_1.sv
// N-to-1 single-bit selector; indices at or above N yield 0.
// Latency: combinational.
// Backpressure: none.
module mux_n_to_1 #(
    parameter int N = 9,
    parameter int M = 4
) (
    input  logic [N-1:0] data,
    input  logic [M-1:0] sel,
    output logic         y
);

    always_comb begin
        y = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == M'(i)) begin
                y = data[i];
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter capturing one bit of the winning requester's data.
// Latency: one cycle from load (ack) to out_valid.
// Backpressure: out_ready=0 in HOLD freezes outputs and suppresses ack.
module rr_mux_arbiter
    import rcc_mux_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] req_data,
    output logic [N-1:0] ack,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_data,
    output logic [M-1:0] out_sel
);

    state_t       state;
    state_t       state_nxt;
    logic [M-1:0] ptr;
    logic [M-1:0] ptr_nxt;
    logic [M-1:0] win;
    logic         found;
    logic         load;
    logic         win_data;

    // Search wraps at N, not 2**M, so the index never leaves 0..N-1.
    always_comb begin
        int j;
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j[M-1:0]]) begin
                found = 1'b1;
                win   = j[M-1:0];
            end
        end
    end

    assign load    = rst_n && found && ((state == IDLE) || out_ready);
    assign ptr_nxt = (win == M'(N - 1)) ? '0 : win + 1'b1;

    always_comb begin
        ack = '0;
        if (load) begin
            for (int i = 0; i < N; i++) begin
                ack[i] = (win == M'(i));
            end
        end
    end

    mux_n_to_1 #(
        .N(N),
        .M(M)
    ) u_mux (
        .data(req_data),
        .sel (win),
        .y   (win_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready && !load) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sel  <= '0;
            out_data <= 1'b0;
            ptr      <= '0;
        end else if (load) begin
            out_sel  <= win;
            out_data <= win_data;
            ptr      <= ptr_nxt;
        end
    end

    assign out_valid = (state == HOLD);

endmodule
